alu_multicycle: RTL and testbench

//  Execute-stage ALU of the 16-bit CPU; sits directly downstream of ALU control.

---
 rtl/alu_multicycle.sv | 190 +++++++++++++++++++
 tb/tb_alu_multicycle.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : alu_multicycle
//  Purpose  : Execute-stage ALU. Single-cycle logic/arith/shift operations and
//             an iterative shift-add multiplier with a Start/Busy/Done
//             handshake that lets the control FSM stall on MUL.
//  Ports    : Clock      - system clock, rising edge
//             Resetn     - asynchronous active-low reset
//             Start      - request, sampled only while Busy=0
//             Operacioni - 3-bit operation code
//             A, B       - operands (WIDTH bits)
//             Result     - registered result, held until the next Done
//             Zero       - Result == 0, updated with Result
//             Overflow   - signed overflow for ADD/SUB, 0 otherwise
//             Busy       - multiply in progress
//             Done       - one-cycle pulse, Result/flags new and valid
//  Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [2:0]       Operacioni,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done
);

  localparam logic [2:0] c_OP_AND = 3'b000;
  localparam logic [2:0] c_OP_OR  = 3'b001;
  localparam logic [2:0] c_OP_ADD = 3'b010;
  localparam logic [2:0] c_OP_XOR = 3'b011;
  localparam logic [2:0] c_OP_SLL = 3'b100;
  localparam logic [2:0] c_OP_ROR = 3'b101;
  localparam logic [2:0] c_OP_SUB = 3'b110;
  localparam logic [2:0] c_OP_MUL = 3'b111;

  localparam logic [SHW-1:0] c_CNT_LAST = SHW'(WIDTH - 1);
  localparam logic [SHW:0]   c_WIDTH_SH = (SHW + 1)'(WIDTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t           r_state,  w_state_nxt;
  logic [WIDTH-1:0] r_result, w_result_nxt;
  logic             r_zero,   w_zero_nxt;
  logic             r_ovf,    w_ovf_nxt;
  logic             r_done,   w_done_nxt;
  logic [WIDTH-1:0] r_acc,    w_acc_nxt;
  logic [WIDTH-1:0] r_mcand,  w_mcand_nxt;
  logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
  logic [SHW-1:0]   r_cnt,    w_cnt_nxt;

  // ---------------------------------------------------------------------------
  // Single-cycle operation datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [SHW-1:0]   w_shamt;
  logic [SHW:0]     w_lshamt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;
  logic [WIDTH-1:0] w_acc_sum;

  assign w_sum    = A + B;
  assign w_diff   = A - B;
  assign w_shamt  = B[SHW-1:0];
  // Left-shift companion of the rotate; a shift of WIDTH (amount 0) yields 0,
  // so ROR by 0 returns A unchanged.
  assign w_lshamt = c_WIDTH_SH - {1'b0, w_shamt};

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (Operacioni)
      c_OP_AND: w_alu_res = A & B;
      c_OP_OR:  w_alu_res = A | B;
      c_OP_ADD: begin
        w_alu_res = w_sum;
        w_alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
      end
      c_OP_XOR: w_alu_res = A ^ B;
      c_OP_SLL: w_alu_res = A << w_shamt;
      c_OP_ROR: w_alu_res = (A >> w_shamt) | (A << w_lshamt);
      c_OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
      end
      default:  w_alu_res = '0;  // MUL handled by the iterative unit
    endcase
  end

  // One shift-add step; the sum is truncated to WIDTH bits.
  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  // ---------------------------------------------------------------------------
  // Control FSM: next state and next register values
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_result_nxt = r_result;
    w_zero_nxt   = r_zero;
    w_ovf_nxt    = r_ovf;
    w_done_nxt   = 1'b0;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (Operacioni == c_OP_MUL) begin
            w_state_nxt  = S_MUL;
            w_acc_nxt    = '0;
            w_mcand_nxt  = A;
            w_mplier_nxt = B;
            w_cnt_nxt    = '0;
          end else begin
            w_result_nxt = w_alu_res;
            w_zero_nxt   = (w_alu_res == '0);
            w_ovf_nxt    = w_alu_ovf;
            w_done_nxt   = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (r_cnt == c_CNT_LAST) begin
          // Last iteration: publish the sum directly instead of the accumulator.
          w_state_nxt  = S_IDLE;
          w_result_nxt = w_acc_sum;
          w_zero_nxt   = (w_acc_sum == '0);
          w_ovf_nxt    = 1'b0;
          w_done_nxt   = 1'b1;
        end else begin
          w_acc_nxt    = w_acc_sum;
          w_mcand_nxt  = r_mcand << 1;
          w_mplier_nxt = r_mplier >> 1;
          w_cnt_nxt    = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_result <= w_result_nxt;
      r_zero   <= w_zero_nxt;
      r_ovf    <= w_ovf_nxt;
      r_done   <= w_done_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign Result   = r_result;
  assign Zero     = r_zero;
  assign Overflow = r_ovf;
  assign Done     = r_done;
  // Busy falls in the same cycle Done rises, so a Start there is accepted.
  assign Busy     = (r_state == S_MUL);

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_multicycle
//  Purpose  : Scoreboard bench for alu_multicycle. Stimulus pushes the
//             expected Result/Zero/Overflow for each accepted operation; a
//             monitor pops and compares on every Done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_multicycle;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        zero;
  logic        ovf;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] res;
    logic        z;
    logic        v;
    string       tag;
  } exp_t;

  exp_t sb[$];

  alu_multicycle #(.WIDTH(16), .SHW(4)) dut (
    .Clock      (clk),
    .Resetn     (rst_n),
    .Start      (start),
    .Operacioni (op),
    .A          (a),
    .B          (b),
    .Result     (result),
    .Zero       (zero),
    .Overflow   (ovf),
    .Busy       (busy),
    .Done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every Done must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_result"},   32'(result), 32'(e.res));
        chk({e.tag, "_zero"},     32'(zero),   32'(e.z));
        chk({e.tag, "_overflow"}, 32'(ovf),    32'(e.v));
      end
    end
  end

  task automatic drive(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] er, input logic ez, input logic ev, input string tag);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e.res = er;
    e.z   = ez;
    e.v   = ev;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Single-cycle op: accept at the next edge, Done one cycle later.
  task automatic single(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] er, input logic ez, input logic ev, input string tag);
    @(posedge clk); #1;
    drive(o, x, y, er, ez, ev, tag);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  // MUL with latency and Busy-length checks; optionally pokes a Start mid-run.
  task automatic run_mul(input logic [15:0] x, input logic [15:0] y, input logic [15:0] er,
                         input logic ez, input bit poke, input string tag);
    int busy_cnt;
    int done_at;
    busy_cnt = 0;
    done_at  = 0;
    @(posedge clk); #1;
    drive(OP_MUL, x, y, er, ez, 1'b0, tag);
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (poke && n == 5) begin
        start = 1'b1; op = OP_AND; a = 16'hFFFF; b = 16'hFFFF;
      end
      if (poke && n == 6) start = 1'b0;
      if (done) begin
        done_at = n;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(done_at), 32'd17);
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd16);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'b000;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_zero",   32'(zero),   32'd0);
    chk("reset_ovf",    32'(ovf),    32'd0);
    chk("reset_busy",   32'(busy),   32'd0);
    chk("reset_done",   32'(done),   32'd0);
    rst_n = 1'b1;

    // Test 1: signed overflow on ADD
    single(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, "add_ovf");

    // Test 2: SUB to zero followed immediately by AND; Done stays high
    @(posedge clk); #1;
    drive(OP_SUB, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, "sub_zero");
    @(posedge clk); #1;
    drive(OP_AND, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0, "and");
    @(negedge clk);
    chk("b2b_done1", 32'(done), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("b2b_done2", 32'(done), 32'd1);
    @(negedge clk);
    chk("b2b_done_end", 32'(done), 32'd0);

    // Remaining single-cycle codes and arithmetic corners
    single(OP_OR,  16'hA000, 16'h0005, 16'hA005, 1'b0, 1'b0, "or");
    single(OP_XOR, 16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 1'b0, "xor");
    single(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, "sub_ovf");
    single(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, "add_wrap");

    // Test 3: MUL with an ignored Start pulse mid-run
    run_mul(16'h0123, 16'h0010, 16'h1230, 1'b0, 1'b1, "mul_0123x10");

    // Test 4: MUL corners
    run_mul(16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, "mul_ffff_sq");
    run_mul(16'h0000, 16'hABCD, 16'h0000, 1'b1, 1'b0, "mul_zero");

    // Test 5: shifts and rotates
    single(OP_ROR, 16'h8001, 16'h0001, 16'hC000, 1'b0, 1'b0, "ror1");
    single(OP_SLL, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, "sll15");
    single(OP_SLL, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, "sll_upper_ign");
    single(OP_ROR, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, "ror0");

    // Test 6: reset during MUL cycle 5 aborts it
    @(posedge clk); #1;
    start = 1'b1; op = OP_MUL; a = 16'h00FF; b = 16'h0101;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_zero",   32'(zero),   32'd0);
    chk("abort_ovf",    32'(ovf),    32'd0);
    chk("abort_busy",   32'(busy),   32'd0);
    chk("abort_done",   32'(done),   32'd0);
    ndone = 0;
    for (int n = 0; n < 24; n++) begin
      @(negedge clk);
      if (n == 2) rst_n = 1'b1;
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_mul(16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, "mul_after_reset");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
